// File: rtl/alu_pkg.sv
// Shared definitions for the ALU request arbiter: operand/result widths,
// opcode and FSM state encodings, and the ALU evaluation helpers.
package alu_pkg;

   localparam int OPND_W = 3;
   localparam int RES_W  = 4;

   typedef enum logic [1:0] {
      OP_ADD = 2'b00,
      OP_SUB = 2'b01,
      OP_AND = 2'b10,
      OP_OR  = 2'b11
   } alu_op_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      EXEC = 2'b01,
      RESP = 2'b10
   } state_e;

   // Operands are zero-extended to the result width before the operation,
   // so SUB wraps modulo 2**RES_W and AND/OR always leave the top bit clear.
   function automatic logic [RES_W-1:0] alu_eval(input logic [OPND_W-1:0] a,
                                                 input logic [OPND_W-1:0] b,
                                                 input alu_op_e           op);
      logic [RES_W-1:0] ax;
      logic [RES_W-1:0] bx;
      ax = RES_W'(a);
      bx = RES_W'(b);
      case (op)
         OP_ADD:  return ax + bx;
         OP_SUB:  return ax - bx;
         OP_AND:  return ax & bx;
         default: return ax | bx;
      endcase
   endfunction

   // {carry/borrow, zero}; the ADD "carry" is bit 3 of the 4-bit sum.
   function automatic logic [1:0] alu_flags(input logic [OPND_W-1:0] a,
                                            input logic [OPND_W-1:0] b,
                                            input alu_op_e           op,
                                            input logic [RES_W-1:0]  z);
      logic carry;
      case (op)
         OP_ADD:  carry = z[RES_W-1];
         OP_SUB:  carry = (a < b);
         default: carry = 1'b0;
      endcase
      return {carry, (z == '0)};
   endfunction

endpackage

// File: rtl/alu_rr_pick.sv
// Combinational round-robin picker: returns the first valid index after
// `last` (wrapping modulo NUM_REQ) and whether any request is valid.
module alu_rr_pick #(
   parameter int NUM_REQ = 2,
   parameter int ID_W    = 1
) (
   input  logic [NUM_REQ-1:0] req_valid,
   input  logic [ID_W-1:0]    last,
   output logic [ID_W-1:0]    grant,
   output logic               any_valid
);

   int best_dist;

   // Each index is ranked by its distance after `last`; the nearest valid
   // one wins, which gives the rotating priority without a variable index.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first, so
      //       no path through the block leaves it unassigned (no latch).
      grant     = '0;
      any_valid = 1'b0;
      best_dist = NUM_REQ;
      for (int idx = 0; idx < NUM_REQ; idx++) begin
         if (req_valid[idx] &&
             ((idx + NUM_REQ - int'(last) - 1) % NUM_REQ) < best_dist) begin
            best_dist = (idx + NUM_REQ - int'(last) - 1) % NUM_REQ;
            grant     = ID_W'(idx);
            any_valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/alu_req_arbiter.sv
// Round-robin arbiter sharing one registered 3-bit ALU between NUM_REQ
// requesters. Define ALU_ARB_FLAGS_EN to add the rsp_flags output.
module alu_req_arbiter
   import alu_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int ID_W    = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_REQ-1:0]       req_valid,
   output logic [NUM_REQ-1:0]       req_ready,
   input  logic [OPND_W*NUM_REQ-1:0] req_a,
   input  logic [OPND_W*NUM_REQ-1:0] req_b,
   input  logic [2*NUM_REQ-1:0]     req_op,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [ID_W-1:0]          rsp_id,
   output logic [RES_W-1:0]         rsp_z,
`ifdef ALU_ARB_FLAGS_EN
   output logic [1:0]               rsp_flags,
`endif
   output logic                     busy
);

   state_e             state;
   state_e             state_nxt;
   logic [ID_W-1:0]    last;
   logic [ID_W-1:0]    grant;
   logic               any_valid;

   logic [OPND_W-1:0]  sel_a;
   logic [OPND_W-1:0]  sel_b;
   alu_op_e            sel_op;

   logic [OPND_W-1:0]  lat_a;
   logic [OPND_W-1:0]  lat_b;
   alu_op_e            lat_op;
   logic [ID_W-1:0]    lat_id;
   logic [RES_W-1:0]   exec_z;

   alu_rr_pick #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_pick (
      .req_valid (req_valid),
      .last      (last),
      .grant     (grant),
      .any_valid (any_valid)
   );

   // Operand mux for the granted requester.
   always_comb begin
      sel_a  = '0;
      sel_b  = '0;
      sel_op = OP_ADD;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant == ID_W'(i)) begin
            sel_a  = req_a[i*OPND_W +: OPND_W];
            sel_b  = req_b[i*OPND_W +: OPND_W];
            sel_op = alu_op_e'(req_op[i*2 +: 2]);
         end
      end
   end

   assign exec_z = alu_eval(lat_a, lat_b, lat_op);

   // State register.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every
      //       register samples pre-edge values regardless of block order.
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (any_valid) state_nxt = EXEC;
         EXEC:    state_nxt = RESP;
         RESP:    if (rsp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Outputs decoded from state; the grant is offered only while IDLE.
   always_comb begin
      req_ready = '0;
      busy      = (state != IDLE);
      if (state == IDLE && any_valid) req_ready = NUM_REQ'(1) << grant;
   end

   // Datapath: latch the winner in IDLE, register the result in EXEC,
   // and hold it in RESP until the consumer takes it.
   always_ff @(posedge clk) begin
      if (rst) begin
         last      <= ID_W'(NUM_REQ - 1);
         lat_a     <= '0;
         lat_b     <= '0;
         lat_op    <= OP_ADD;
         lat_id    <= '0;
         rsp_valid <= 1'b0;
         rsp_z     <= '0;
         rsp_id    <= '0;
`ifdef ALU_ARB_FLAGS_EN
         rsp_flags <= 2'b00;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (any_valid) begin
                  lat_a  <= sel_a;
                  lat_b  <= sel_b;
                  lat_op <= sel_op;
                  lat_id <= grant;
                  last   <= grant;
               end
            end
            EXEC: begin
               rsp_z     <= exec_z;
               rsp_id    <= lat_id;
               rsp_valid <= 1'b1;
`ifdef ALU_ARB_FLAGS_EN
               rsp_flags <= alu_flags(lat_a, lat_b, lat_op, exec_z);
`endif
            end
            RESP: begin
               if (rsp_ready) rsp_valid <= 1'b0;
            end
            default: rsp_valid <= 1'b0;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Self-checking bench for alu_req_arbiter: directed cases with literal
// expectations plus randomized traffic against a transaction-level model.
module tb_alu_req_arbiter;

   localparam int NUM_REQ = 2;
   localparam int ID_W    = 1;

   logic                  clk = 1'b0;
   logic                  rst;
   logic [NUM_REQ-1:0]    req_valid;
   logic [NUM_REQ-1:0]    req_ready;
   logic [3*NUM_REQ-1:0]  req_a;
   logic [3*NUM_REQ-1:0]  req_b;
   logic [2*NUM_REQ-1:0]  req_op;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [ID_W-1:0]       rsp_id;
   logic [3:0]            rsp_z;
   logic                  busy;
`ifdef ALU_ARB_FLAGS_EN
   logic [1:0]            rsp_flags;
`endif

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   alu_req_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_op    (req_op),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_z     (rsp_z),
`ifdef ALU_ARB_FLAGS_EN
      .rsp_flags (rsp_flags),
`endif
      .busy      (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- behavioural model ----------------
   function automatic int alu_model(input int a, input int b, input int op);
      case (op)
         0:       return (a + b) % 16;
         1:       return (a - b + 16) % 16;
         2:       return a & b;
         default: return a | b;
      endcase
   endfunction

   function automatic int flag_model(input int a, input int b, input int op);
      int z = alu_model(a, b, op);
      int c = (op == 0) ? ((z >> 3) & 1) : (op == 1) ? int'(a < b) : 0;
      return c * 2 + int'(z == 0);
   endfunction

   function automatic int pick(input logic [NUM_REQ-1:0] v, input int last);
      for (int k = 1; k <= NUM_REQ; k++)
         if (v[(last + k) % NUM_REQ]) return (last + k) % NUM_REQ;
      return -1;
   endfunction

   // One transaction may be outstanding; its result is visible from the
   // second edge after acceptance until the consumer takes it.
   bit                 m_busy  = 1'b0;
   int                 m_age   = 0;
   int                 m_last  = NUM_REQ - 1;
   int                 m_z, m_id, m_flags;
   int                 grant_log[$];
   logic [NUM_REQ-1:0] saw_ready = '0;
   logic [NUM_REQ-1:0] exp_ready;
   int                 g;
   int                 ga, gb, gop;

   always @(negedge clk) begin
      g         = m_busy ? -1 : pick(req_valid, m_last);
      exp_ready = '0;
      if (g >= 0) exp_ready[g] = 1'b1;
      if (!rst) check("req_ready", req_ready, exp_ready);
      check("busy", busy, m_busy);
      check("rsp_valid", rsp_valid, m_busy && m_age >= 2);
      if (m_busy && m_age >= 2) begin
         check("rsp_z", rsp_z, m_z);
         check("rsp_id", rsp_id, m_id);
`ifdef ALU_ARB_FLAGS_EN
         check("rsp_flags", rsp_flags, m_flags);
`endif
      end
      saw_ready = rst ? '0 : req_ready;
      if (rst) begin
         m_busy = 1'b0;
         m_last = NUM_REQ - 1;
      end else if (!m_busy) begin
         if (g >= 0) begin
            ga      = int'(req_a[3*g +: 3]);
            gb      = int'(req_b[3*g +: 3]);
            gop     = int'(req_op[2*g +: 2]);
            m_z     = alu_model(ga, gb, gop);
            m_flags = flag_model(ga, gb, gop);
            m_id    = g;
            m_last  = g;
            m_busy  = 1'b1;
            m_age   = 1;
            grant_log.push_back(g);
         end
      end else if (m_age >= 2) begin
         if (rsp_ready) m_busy = 1'b0;
      end else begin
         m_age++;
      end
   end

   // ---------------- directed helpers ----------------
   task automatic wait_grant(input int id, output bit ok);
      ok = 1'b0;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         if (req_ready[id]) begin ok = 1'b1; break; end
      end
      check("grant_timeout", ok, 1);
   endtask

   task automatic wait_rsp(output bit ok);
      ok = 1'b0;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         if (rsp_valid) begin ok = 1'b1; break; end
      end
      check("rsp_timeout", ok, 1);
   endtask

   task automatic wait_idle();
      bit ok = 1'b0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (!busy && !rsp_valid) begin ok = 1'b1; break; end
      end
      check("idle_timeout", ok, 1);
   endtask

   task automatic reset_dut();
      @(posedge clk); #1;
      rst       = 1'b1;
      req_valid = '0;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic do_op(input int id, input int a, input int b, input int op,
                        input int exp_z, input int exp_fl, input string name);
      int t0;
      bit ok;
      @(posedge clk); #1;
      req_a[3*id +: 3]  = 3'(a);
      req_b[3*id +: 3]  = 3'(b);
      req_op[2*id +: 2] = 2'(op);
      req_valid[id]     = 1'b1;
      wait_grant(id, ok);
      t0 = cyc;
      @(posedge clk); #1;
      req_valid[id] = 1'b0;
      wait_rsp(ok);
      if (ok) begin
         check({name, "_latency"}, cyc - t0, 2);
         check({name, "_z"}, rsp_z, exp_z);
         check({name, "_id"}, rsp_id, id);
`ifdef ALU_ARB_FLAGS_EN
         check({name, "_flags"}, rsp_flags, exp_fl);
`endif
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      bit ok;
      rst       = 1'b1;
      req_valid = '0;
      req_a     = '0;
      req_b     = '0;
      req_op    = '0;
      rsp_ready = 1'b1;

      // Reset values.
      repeat (2) @(negedge clk);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_z", rsp_z, 0);
      check("rst_rsp_id", rsp_id, 0);
      check("rst_req_ready", req_ready, 0);
      check("rst_busy", busy, 0);
`ifdef ALU_ARB_FLAGS_EN
      check("rst_flags", rsp_flags, 0);
`endif
      @(posedge clk); #1;
      rst = 1'b0;

      // Arithmetic and logic cases with hand-computed results.
      do_op(0, 3, 4, 0, 4'h7, 2'b00, "add");
      do_op(1, 1, 2, 1, 4'hF, 2'b10, "sub_wrap");
      do_op(0, 3, 3, 1, 4'h0, 2'b01, "sub_zero");
      do_op(1, 7, 7, 0, 4'hE, 2'b10, "add_max");
      do_op(0, 6, 3, 2, 4'h2, 2'b00, "and");
      do_op(1, 5, 2, 3, 4'h7, 2'b00, "or");
      do_op(0, 4, 3, 2, 4'h0, 2'b01, "and_zero");

      // Fairness: both requesters continuously valid.
      wait_idle();
      reset_dut();
      req_a = {3'd5, 3'd2};
      req_b = {3'd6, 3'd1};
      req_op = {2'd1, 2'd0};
      req_valid = 2'b11;
      grant_log.delete();
      for (int c = 0; c < 60; c++) begin
         @(posedge clk);
         if (grant_log.size() >= 6) break;
      end
      #1 req_valid = '0;
      check("fair_count", grant_log.size() >= 6, 1);
      for (int k = 0; k < 6 && k < grant_log.size(); k++)
         check($sformatf("fair_grant%0d", k), grant_log[k], k % 2);
      wait_idle();

      // Back-pressure: result held stable and no new grant while blocked.
      @(posedge clk); #1;
      rsp_ready    = 1'b0;
      req_a[2:0]   = 3'd3;
      req_b[2:0]   = 3'd4;
      req_op[1:0]  = 2'd0;
      req_valid[0] = 1'b1;
      wait_grant(0, ok);
      wait_rsp(ok);
      repeat (5) begin
         @(negedge clk);
         check("bp_rsp_valid", rsp_valid, 1);
         check("bp_rsp_z", rsp_z, 4'h7);
         check("bp_rsp_id", rsp_id, 0);
         check("bp_req_ready", req_ready, 0);
      end
      @(posedge clk); #1;
      rsp_ready = 1'b1;
      @(negedge clk);
      check("bp_handshake_ready", req_ready, 2'b00);
      @(negedge clk);
      check("bp_resume_ready", req_ready, 2'b01);
      @(posedge clk); #1;
      req_valid = '0;
      wait_idle();

      // Reset while the operation is in EXEC.
      reset_dut();
      req_a[5:3]  = 3'd1;
      req_b[5:3]  = 3'd2;
      req_op[3:2] = 2'd1;
      req_valid   = 2'b10;
      wait_grant(1, ok);
      @(posedge clk); #1;
      rst         = 1'b1;
      req_a[2:0]  = 3'd2;
      req_b[2:0]  = 3'd2;
      req_op[1:0] = 2'd0;
      req_valid   = 2'b11;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("midrst_rsp_valid", rsp_valid, 0);
      check("midrst_busy", busy, 0);
      check("midrst_regrant", req_ready, 2'b01);
      @(posedge clk); #1;
      req_valid = '0;
      wait_idle();

      // Randomized traffic checked by the model.
      for (int c = 0; c < 3000; c++) begin
         @(posedge clk); #1;
         for (int i = 0; i < NUM_REQ; i++) begin
            if (!req_valid[i] || saw_ready[i]) begin
               req_valid[i] = ($urandom_range(2) == 0) ? 1'b0 : 1'b1;
               req_a[3*i +: 3]  = 3'($urandom_range(7));
               req_b[3*i +: 3]  = 3'($urandom_range(7));
               req_op[2*i +: 2] = 2'($urandom_range(3));
            end else if ($urandom_range(31) == 0) begin
               req_valid[i] = 1'b0;
            end
         end
         rsp_ready = ($urandom_range(3) != 0);
         rst       = ($urandom_range(99) == 0);
      end
      @(posedge clk); #1;
      rst       = 1'b0;
      req_valid = '0;
      rsp_ready = 1'b1;
      wait_idle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
